// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one UART transmit byte stream.
// The owner keeps the grant until end of message, burst limit or stall timeout.
module uart_tx_arbiter #(
   parameter int MAX_BURST    = 16,
   parameter int IDLE_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset_n,

   input  logic [7:0] s0_axis_tdata,
   input  logic       s0_axis_tvalid,
   input  logic       s0_axis_tlast,
   output logic       s0_axis_tready,

   input  logic [7:0] s1_axis_tdata,
   input  logic       s1_axis_tvalid,
   input  logic       s1_axis_tlast,
   output logic       s1_axis_tready,

   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,

   output logic [1:0] grant,
   output logic       busy
);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
   localparam logic [7:0] IDLE_LIM  = 8'(IDLE_TIMEOUT);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_grant_q, last_grant_d;
   logic [7:0] burst_q, burst_d;
   logic [7:0] idle_q, idle_d;
   logic [7:0] data_q, data_d;
   logic       vld_q, vld_d;

   logic       own_valid;
   logic       own_last;
   logic [7:0] own_data;
   logic       own_ready;
   logic       load;
   logic       out_hs;
   logic       burst_hit;
   logic       idle_hit;
   logic       release_own;

   // Owner-side view: only the granted requester's signals matter in OWN.
   assign own_valid = owner_q ? s1_axis_tvalid : s0_axis_tvalid;
   assign own_last  = owner_q ? s1_axis_tlast  : s0_axis_tlast;
   assign own_data  = owner_q ? s1_axis_tdata  : s0_axis_tdata;
   assign own_ready = m_axis_tready | ~vld_q;
   assign load      = (state_q == OWN) & own_valid & own_ready;
   assign out_hs    = vld_q & m_axis_tready;
   assign burst_hit = (burst_q == BURST_LIM - 8'd1);
   assign idle_hit  = (idle_q == IDLE_LIM - 8'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         burst_q      <= 8'd0;
         idle_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         burst_q      <= burst_d;
         idle_q       <= idle_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      burst_d      = burst_q;
      idle_d       = idle_q;
      release_own  = 1'b0;
      if (state_q == IDLE) begin
         if (s0_axis_tvalid | s1_axis_tvalid) begin
            state_d = OWN;
            owner_d = (s0_axis_tvalid & s1_axis_tvalid) ? ~last_grant_q : s1_axis_tvalid;
            burst_d = 8'd0;
            idle_d  = 8'd0;
         end
      end else begin
         if (load) begin
            burst_d     = burst_q + 8'd1;
            idle_d      = 8'd0;
            release_own = own_last | burst_hit;
         end else if (!own_valid) begin
            idle_d      = idle_q + 8'd1;
            release_own = idle_hit;
         end
         // Counters are cleared on release, so they never reach their wrap point.
         if (release_own) begin
            state_d      = IDLE;
            last_grant_d = owner_q;
            burst_d      = 8'd0;
            idle_d       = 8'd0;
         end
      end
   end

   always_comb begin
      s0_axis_tready = 1'b0;
      s1_axis_tready = 1'b0;
      grant          = 2'b00;
      if (state_q == OWN) begin
         if (owner_q) begin
            s1_axis_tready = own_ready;
            grant          = 2'b10;
         end else begin
            s0_axis_tready = own_ready;
            grant          = 2'b01;
         end
      end
   end

   // Output register drains on its own; releasing the grant never flushes it.
   always_comb begin
      data_d = data_q;
      vld_d  = vld_q;
      if (load) begin
         data_d = own_data;
         vld_d  = 1'b1;
      end else if (out_hs) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= 8'd0;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tvalid = vld_q;
   assign busy          = (grant != 2'b00) | vld_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with an ordered expected-byte scoreboard.
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] s0_axis_tdata, s1_axis_tdata;
   logic       s0_axis_tvalid, s1_axis_tvalid;
   logic       s0_axis_tlast, s1_axis_tlast;
   logic       s0_axis_tready, s1_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic [1:0] grant;
   logic       busy;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [7:0] exp_q[$];
   int         out_cyc[$];
   logic [1:0] glog[$];
   logic [1:0] prev_grant;
   int         cyc;
   int         npass;
   int         ntotal;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.MAX_BURST(4), .IDLE_TIMEOUT(8)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .s0_axis_tdata  (s0_axis_tdata),
      .s0_axis_tvalid (s0_axis_tvalid),
      .s0_axis_tlast  (s0_axis_tlast),
      .s0_axis_tready (s0_axis_tready),
      .s1_axis_tdata  (s1_axis_tdata),
      .s1_axis_tvalid (s1_axis_tvalid),
      .s1_axis_tlast  (s1_axis_tlast),
      .s1_axis_tready (s1_axis_tready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .grant          (grant),
      .busy           (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
   endtask

   // One clock: drive sources from their queues at the falling edge, observe
   // the handshakes that the coming rising edge will complete.
   task automatic step();
      logic [7:0] e;
      s0_axis_tvalid = (q0.size() > 0);
      s0_axis_tdata  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      s0_axis_tlast  = (q0.size() > 0) ? q0[0][8]   : 1'b0;
      s1_axis_tvalid = (q1.size() > 0);
      s1_axis_tdata  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      s1_axis_tlast  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
      #1;
      if (m_axis_tvalid && m_axis_tready) begin
         out_cyc.push_back(cyc);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", 32'(m_axis_tdata), 32'(e));
         end else begin
            chk("out_extra", 32'(m_axis_tvalid), 32'd0);
         end
      end
      if (grant != 2'b00 && prev_grant == 2'b00) glog.push_back(grant);
      prev_grant = grant;
      if (s0_axis_tvalid && s0_axis_tready) q0.delete(0);
      if (s1_axis_tvalid && s1_axis_tready) q1.delete(0);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || m_axis_tvalid || grant != 2'b00) && n < 200) begin
         step();
         n++;
      end
      chk({tag, "_finished"}, 32'(n < 200), 32'd1);
      chk({tag, "_all_out"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic clear_inputs();
      q0.delete();
      q1.delete();
      exp_q.delete();
      out_cyc.delete();
      glog.delete();
      prev_grant     = 2'b00;
      s0_axis_tdata  = 8'h00;
      s0_axis_tvalid = 1'b0;
      s0_axis_tlast  = 1'b0;
      s1_axis_tdata  = 8'h00;
      s1_axis_tvalid = 1'b0;
      s1_axis_tlast  = 1'b0;
      m_axis_tready  = 1'b1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      npass = 0;
      ntotal = 0;
      cyc = 0;
      do_reset();

      // reset state
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_mdata", 32'(m_axis_tdata), 32'd0);
      chk("rst_s0_ready", 32'(s0_axis_tready), 32'd0);
      chk("rst_s1_ready", 32'(s1_axis_tready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // single byte from s0
      q0.push_back({1'b1, 8'h55});
      exp_q.push_back(8'h55);
      step();
      chk("c1_grant", 32'(grant), 32'd1);
      chk("c1_s0_ready", 32'(s0_axis_tready), 32'd1);
      step();
      chk("c1_mvalid", 32'(m_axis_tvalid), 32'd1);
      chk("c1_mdata", 32'(m_axis_tdata), 32'h55);
      chk("c1_released", 32'(grant), 32'd0);
      chk("c1_busy", 32'(busy), 32'd1);
      step();
      chk("c1_drained", 32'(m_axis_tvalid), 32'd0);
      chk("c1_idle_busy", 32'(busy), 32'd0);
      chk("c1_all_out", 32'(exp_q.size()), 32'd0);

      // tie: s0 wins after reset, one arbitration gap between messages
      do_reset();
      q0 = '{{1'b0, 8'h10}, {1'b0, 8'h11}, {1'b1, 8'h12}};
      q1 = '{{1'b0, 8'h20}, {1'b0, 8'h21}, {1'b1, 8'h22}};
      exp_q = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
      drain("tie");
      chk("tie_count", 32'(out_cyc.size()), 32'd6);
      if (out_cyc.size() == 6) begin
         chk("tie_b2b", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
         chk("tie_gap", 32'(out_cyc[3] - out_cyc[2]), 32'd2);
      end

      // round-robin with 1-byte messages
      do_reset();
      for (int i = 0; i < 4; i++) begin
         q0.push_back({1'b1, 8'hA0 + 8'(i)});
         q1.push_back({1'b1, 8'hB0 + 8'(i)});
         exp_q.push_back(8'hA0 + 8'(i));
         exp_q.push_back(8'hB0 + 8'(i));
      end
      drain("rr");
      chk("rr_grants", 32'(glog.size()), 32'd8);
      for (int i = 0; i < glog.size(); i++)
         chk("rr_alternate", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

      // burst limit of 4 forces re-arbitration mid-message
      do_reset();
      for (int i = 0; i < 6; i++) q0.push_back({(i == 5), 8'h30 + 8'(i)});
      q1 = '{{1'b0, 8'h40}, {1'b1, 8'h41}};
      exp_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h34, 8'h35};
      drain("burst");
      chk("burst_grants", 32'(glog.size()), 32'd3);
      if (glog.size() == 3) begin
         chk("burst_g0", 32'(glog[0]), 32'd1);
         chk("burst_g1", 32'(glog[1]), 32'd2);
         chk("burst_g2", 32'(glog[2]), 32'd1);
      end

      // output stall for 20 cycles with a byte pending
      do_reset();
      m_axis_tready = 1'b0;
      q0 = '{{1'b0, 8'h50}, {1'b0, 8'h51}, {1'b1, 8'h52}};
      exp_q = '{8'h50, 8'h51, 8'h52};
      step();
      step();
      for (int i = 0; i < 20; i++) begin
         step();
         chk("stall_mdata", 32'(m_axis_tdata), 32'h50);
         chk("stall_s0_ready", 32'(s0_axis_tready), 32'd0);
         chk("stall_mvalid", 32'(m_axis_tvalid), 32'd1);
      end
      chk("stall_held", 32'(q0.size()), 32'd2);
      m_axis_tready = 1'b1;
      drain("stall");

      // idle timeout of 8 cycles revokes the stalled owner
      do_reset();
      q0.push_back({1'b0, 8'h60});
      q1.push_back({1'b1, 8'h70});
      exp_q = '{8'h60, 8'h70};
      step();
      chk("to_grant_s0", 32'(grant), 32'd1);
      step();
      for (int i = 0; i < 7; i++) step();
      chk("to_still_owned", 32'(grant), 32'd1);
      step();
      chk("to_revoked", 32'(grant), 32'd0);
      step();
      chk("to_grant_s1", 32'(grant), 32'd2);
      q0 = '{{1'b0, 8'h61}, {1'b1, 8'h62}};
      exp_q.push_back(8'h61);
      exp_q.push_back(8'h62);
      drain("timeout");

      // asynchronous reset mid-transfer discards the pending byte
      q0 = '{{1'b0, 8'h80}, {1'b0, 8'h81}, {1'b1, 8'h82}};
      step();
      step();
      chk("mid_pending", 32'(m_axis_tvalid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_mvalid", 32'(m_axis_tvalid), 32'd0);
      chk("arst_mdata", 32'(m_axis_tdata), 32'd0);
      chk("arst_s0_ready", 32'(s0_axis_tready), 32'd0);
      chk("arst_s1_ready", 32'(s1_axis_tready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      clear_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      q1.push_back({1'b1, 8'h99});
      exp_q.push_back(8'h99);
      step();
      chk("resume_grant", 32'(grant), 32'd2);
      drain("resume");

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 16: maximum bytes per grant before forced re-arbitration (range 1..255).
REQ-002 Parameter IDLE_TIMEOUT, default 255: cycles a granted source may stall with tvalid=0 before the grant is revoked (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s0_axis_tdata  input  8  requester 0 byte.
REQ-006 s0_axis_tvalid  input  1  requester 0 byte valid.
REQ-007 s0_axis_tlast  input  1  requester 0 end of message.
REQ-008 s0_axis_tready  output  1  requester 0 byte accepted.
REQ-009 s1_axis_tdata, s1_axis_tvalid, s1_axis_tlast, s1_axis_tready: same directions, widths and meanings as the s0 ports, for requester 1.
REQ-010 m_axis_tdata  output  8  byte to the UART transmit stream input.
REQ-011 m_axis_tvalid  output  1  output byte valid.
REQ-012 m_axis_tready  input  1  UART transmit stream ready.
REQ-013 grant  output  2  one-hot current owner; 2'b00 when no owner.
REQ-014 busy  output  1  high when grant!=0 or m_axis_tvalid=1.

Function
REQ-015 The FSM SHALL have two states, IDLE and OWN.
REQ-016 IDLE, exactly one s*_axis_tvalid high: that requester SHALL be granted and the FSM SHALL move to OWN on the next edge.
REQ-017 IDLE, both tvalid high: the grant SHALL go to the requester not recorded in last_grant (round-robin).
REQ-018 IDLE, no tvalid high: the FSM SHALL remain in IDLE.
REQ-019 In IDLE, both s*_axis_tready SHALL be 0, so arbitration costs 1 cycle.
REQ-020 In OWN, the granted tready SHALL equal (m_axis_tready OR NOT m_axis_tvalid); the non-granted tready SHALL be 0.
REQ-021 A granted handshake SHALL load tdata into the output register, set m_axis_tvalid=1 on the next edge (latency 1 cycle), and increment the burst counter.
REQ-022 An output handshake without a simultaneous load SHALL clear m_axis_tvalid.
REQ-023 A simultaneous output handshake and load SHALL keep m_axis_tvalid=1 with the new data, giving back-to-back throughput of 1 byte/cycle.
REQ-024 The grant SHALL be released (to IDLE, grant=0, last_grant=owner, counters cleared) on the edge following an accepted byte with tlast=1.
REQ-025 The grant SHALL also be released when the accepted byte brings the burst count to MAX_BURST; the remainder of the message is re-arbitrated.
REQ-026 The idle counter SHALL increment each OWN cycle in which the owner's tvalid=0, and clear on any owner handshake.
REQ-027 The grant SHALL be released when the idle counter reaches IDLE_TIMEOUT.
REQ-028 Release SHALL NOT flush the output register; a pending byte drains independently while the next arbitration proceeds.
REQ-029 Data SHALL never be dropped or duplicated; tdata on either port SHALL be ignored while that port's tready=0.
REQ-030 The burst and idle counters SHALL be 8 bits and SHALL never wrap, because release occurs at the limit.
REQ-031 tlast and the MAX_BURST limit on the same byte SHALL cause a single release.

Reset
REQ-032 Asserting reset_n=0 SHALL immediately force IDLE, grant=0, m_axis_tvalid=0, m_axis_tdata=0, both tready=0, busy=0, counters=0, and last_grant=requester 1 (so requester 0 wins the first tie).
REQ-033 Reset asserted mid-message SHALL discard the pending output byte; after reset_n=1, operation SHALL resume from IDLE on the first clk edge.

Verification
REQ-034 Bench case, reset: release reset, s0 sends 0x55 with tlast, m_axis_tready=1 -> grant=01 one cycle after tvalid, m_axis_tdata=0x55 one cycle after the handshake, then grant=00.
REQ-035 Bench case, tie: s0 and s1 both valid, each sending a 3-byte message (0x10,0x11,0x12 / 0x20,0x21,0x22) -> output order s0 bytes then s1 bytes, with one arbitration-gap cycle between messages.
REQ-036 Bench case, round-robin: s0 and s1 continuously valid with 1-byte messages -> grants alternate 01,10,01,10 and neither requester is served twice in a row.
REQ-037 Bench case, MAX_BURST: MAX_BURST=4, s0 sends 6 bytes with tlast on the 6th while s1 is valid -> 4 s0 bytes, then s1's message, then the remaining 2 s0 bytes.
REQ-038 Bench case, stall: m_axis_tready=0 for 20 cycles with a byte pending -> m_axis_tdata stable, owner tready=0, no loss, and correct order after tready=1.
REQ-039 Bench case, timeout and reset: with IDLE_TIMEOUT=8, the owner drops tvalid mid-message -> grant revoked after 8 cycles and s1 served; reset_n pulsed low mid-transfer -> all outputs 0 asynchronously.
